// File: rtl/trig_turf_serializer_pkg.sv
// Shared definitions for the SURF-to-TURF trigger serializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the default framing characters, the trigger-word header constant,
// the frame slot indices, the counter width and the frame-kind state type.
package trig_ser_pkg;

    // Default slot-0 characters for idle and trigger frames.
    localparam logic [7:0] IDLE_CHAR_DEF = 8'h3C;
    localparam logic [7:0] TRIG_CHAR_DEF = 8'hBC;

    // Required value of tdata[31:30] on a well-formed trigger word.
    localparam logic [1:0] TRIG_HDR = 2'b10;

    // Slot counter width covers both legal frame lengths (8 and 16).
    localparam int SLOT_W = 4;

    localparam logic [SLOT_W-1:0] SLOT_HDR          = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_ADDR_HI      = 4'd1;
    localparam logic [SLOT_W-1:0] SLOT_ADDR_LO_META = 4'd2;
    localparam logic [SLOT_W-1:0] SLOT_META_SEQ     = 4'd3;

    // Width of the saturating statistics counters.
    localparam int CNT_W = 16;

    // FR_OFF only exists while in reset and for the release edge; it makes
    // the first frame after release start at slot 0.
    typedef enum logic [1:0] {
        FR_OFF  = 2'd0,
        FR_IDLE = 2'd1,
        FR_TRIG = 2'd2
    } frame_state_e;

    // Layout of a 32-bit trigger word from the generator FIFO.
    typedef struct packed {
        logic [1:0]  hdr;
        logic [11:0] addr;
        logic [9:0]  pad;
        logic [7:0]  meta;
    } trig_word_t;

    // A word is usable only with the right header and all-zero padding.
    function automatic logic word_ok(input trig_word_t w);
        return (w.hdr == TRIG_HDR) && (w.pad == '0);
    endfunction

endpackage

// File: rtl/trig_turf_serializer_if.sv
// AXI4-Stream trigger-word channel between the generator FIFO and the serializer.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready; the word holds while tvalid && !tready.
//
// Signals: tdata[31:0] trigger word, tvalid from source, tready from sink.
interface trig_turf_serializer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/trig_turf_serializer_sat_counter.sv
// Saturating up-counter for link statistics.
// Latency: count_o reflects inc_i one clock after it is sampled.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports: ifclk clock, rstn_i sync active-low reset, inc_i increment enable,
//        count_o current count.
module trig_sat_counter
    import trig_ser_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             ifclk,
    input  logic             rstn_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge ifclk) begin
        if (!rstn_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/trig_turf_serializer.sv
// Serializes trigger words into fixed-length byte frames toward the TURF.
// Latency: a word accepted in the last slot appears as TRIG_CHAR on dout_o the next clock.
// Backpressure: tready pulses only in the last slot when enabled; otherwise upstream holds.
//
// Ports: ifclk clock; rstn_i sync active-low reset; enable_i allows acceptance;
//        s_trig trigger-word stream (slave); dout_o link byte; frame_start_o
//        high on slot 0; trig_count_o / err_count_o saturating counters;
//        seq_o sequence number of the most recent trigger frame.
module trig_turf_serializer
    import trig_ser_pkg::*;
#(
    parameter int         FRAME_LEN = 8,
    parameter logic [7:0] IDLE_CHAR = IDLE_CHAR_DEF,
    parameter logic [7:0] TRIG_CHAR = TRIG_CHAR_DEF,
    parameter             IFCLKTYPE = "NONE"
) (
    input  logic                   ifclk,
    input  logic                   rstn_i,
    input  logic                   enable_i,
    trig_turf_serializer_if.slave  s_trig,
    output logic [7:0]             dout_o,
    output logic                   frame_start_o,
    output logic [CNT_W-1:0]       trig_count_o,
    output logic [CNT_W-1:0]       err_count_o,
    output logic [3:0]             seq_o
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_LEN - 1);

    frame_state_e      state_q, state_n;
    logic [SLOT_W-1:0] slot_q, slot_n;

    logic [11:0] addr_q, addr_n;
    logic [7:0]  meta_q, meta_n;
    logic [3:0]  seq_q, seq_n;

    (* CUSTOM_CC_SRC = IFCLKTYPE *) logic [7:0] dout_q;
    logic [7:0] dout_n;
    logic       frame_start_q, frame_start_n;
    logic       tready_q, tready_n;

    trig_word_t word;
    logic       xfer, xfer_ok, xfer_bad;
    logic       start_trig;

    logic [7:0] b_addr_hi, b_addr_lo_meta, b_meta_seq;

    assign word     = trig_word_t'(s_trig.tdata);
    assign xfer     = s_trig.tvalid && tready_q;
    assign xfer_ok  = xfer && word_ok(word);
    assign xfer_bad = xfer && !word_ok(word);

    // Slot the outputs will show after the coming edge. Leaving FR_OFF
    // always lands on slot 0 so the first post-reset frame is aligned.
    always_comb begin
        slot_n = slot_q + 1'b1;
        if ((state_q == FR_OFF) || (slot_q == SLOT_LAST)) begin
            slot_n = '0;
        end
    end

    // State register: frame kind and slot position.
    always_ff @(posedge ifclk) begin
        if (!rstn_i) begin
            state_q <= FR_OFF;
            slot_q  <= '0;
        end else begin
            state_q <= state_n;
            slot_q  <= slot_n;
        end
    end

    // Next state: frame kind is chosen only at a frame boundary. Since a
    // transfer can only happen in the last slot, a good transfer there is
    // exactly the pending condition for the frame about to begin.
    always_comb begin
        state_n = state_q;
        if (slot_n == '0) begin
            state_n = xfer_ok ? FR_TRIG : FR_IDLE;
        end
    end

    assign start_trig = (slot_n == '0) && (state_n == FR_TRIG);

    // Latched trigger fields. They only change on a good transfer, which
    // coincides with a frame boundary, so bytes stay stable within a frame.
    always_comb begin
        addr_n = addr_q;
        meta_n = meta_q;
        seq_n  = seq_q;
        if (xfer_ok) begin
            addr_n = word.addr;
            meta_n = word.meta;
        end
        if (start_trig) begin
            seq_n = seq_q + 4'd1;
        end
    end

    // Output logic: byte for the upcoming slot, computed from next-state
    // values so every output can be registered without an extra delay.
    always_comb begin
        b_addr_hi      = '0;
        b_addr_lo_meta = '0;
        b_meta_seq     = '0;
        if (state_n == FR_TRIG) begin
            b_addr_hi      = addr_n[11:4];
            b_addr_lo_meta = {addr_n[3:0], meta_n[7:4]};
            b_meta_seq     = {meta_n[3:0], seq_n};
        end

        case (slot_n)
            SLOT_HDR:          dout_n = (state_n == FR_TRIG) ? TRIG_CHAR : IDLE_CHAR;
            SLOT_ADDR_HI:      dout_n = b_addr_hi;
            SLOT_ADDR_LO_META: dout_n = b_addr_lo_meta;
            SLOT_META_SEQ:     dout_n = b_meta_seq;
            default: begin
                // Remaining payload slots are zero, so the checksum only
                // needs the three populated bytes; idle frames give 8'hFF.
                if (slot_n == SLOT_LAST) begin
                    dout_n = ~(b_addr_hi ^ b_addr_lo_meta ^ b_meta_seq);
                end else begin
                    dout_n = '0;
                end
            end
        endcase

        frame_start_n = (slot_n == '0);
        tready_n      = (slot_n == SLOT_LAST) && enable_i;
    end

    // Registered outputs and datapath.
    always_ff @(posedge ifclk) begin
        if (!rstn_i) begin
            dout_q        <= '0;
            frame_start_q <= 1'b0;
            tready_q      <= 1'b0;
            addr_q        <= '0;
            meta_q        <= '0;
            seq_q         <= '0;
        end else begin
            dout_q        <= dout_n;
            frame_start_q <= frame_start_n;
            tready_q      <= tready_n;
            addr_q        <= addr_n;
            meta_q        <= meta_n;
            seq_q         <= seq_n;
        end
    end

    trig_sat_counter #(.WIDTH(CNT_W)) u_trig_cnt (
        .ifclk   (ifclk),
        .rstn_i  (rstn_i),
        .inc_i   (start_trig),
        .count_o (trig_count_o)
    );

    trig_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .ifclk   (ifclk),
        .rstn_i  (rstn_i),
        .inc_i   (xfer_bad),
        .count_o (err_count_o)
    );

    assign dout_o        = dout_q;
    assign frame_start_o = frame_start_q;
    assign s_trig.tready = tready_q;
    assign seq_o         = seq_q;

endmodule

// File: doc/trig_turf_serializer.md
Name: trig_turf_serializer

Overview:
- Sits directly downstream of the SURF trigger generator FIFO.
- Consumes its 32-bit AXI4-Stream trigger words and serializes each into a fixed-length byte frame on an 8-bit-per-clock link toward the TURF.
- One trigger is sent per frame, matching the generator's one-trigger-per-8-clocks rate.
- Idle frames are sent when no trigger is pending.

Parameters:
- FRAME_LEN, 8: clocks per frame; legal values are 8 or 16.
- IDLE_CHAR, 8'h3C: slot-0 byte of an idle frame.
- TRIG_CHAR, 8'hBC: slot-0 byte of a trigger frame.
- IFCLKTYPE, "NONE": clock-domain tag for the timing-constraint attributes.

Ports:
- ifclk  in  1  sole clock.
- rstn_i  in  1  reset; synchronous, active-low.
- enable_i  in  1  allow trigger acceptance.
- s_trig_tdata  in  32  trigger word: [31:30]=2'b10, [29:18]=address, [17:16]=0, [15:8]=0, [7:0]=metadata.
- s_trig_tvalid  in  1  AXI4S valid.
- s_trig_tready  out  1  AXI4S ready.
- dout_o  out  8  serialized link byte.
- frame_start_o  out  1  high while dout_o carries slot 0.
- trig_count_o  out  16  frames sent with trigger content; saturating.
- err_count_o  out  16  malformed words dropped; saturating.
- seq_o  out  4  sequence number of the last trigger frame sent.

Behaviour:
- Reset:
  - While rstn_i=0: dout_o=0, frame_start_o=0, s_trig_tready=0, seq_o=0, trig_count_o=0, err_count_o=0, slot counter=0, pending=0.
  - Reset mid-frame aborts the frame immediately; dout_o=0 from the next edge.
  - The first cycle after release is slot 0 of an idle frame.
- Slot counter:
  - slot runs 0..FRAME_LEN-1, then wraps to 0.
  - All outputs are registered; dout_o shows the byte for the current slot.
  - frame_start_o = (slot==0).
- Handshake:
  - s_trig_tready = 1 only in slot FRAME_LEN-1, and only when enable_i=1; 0 otherwise.
  - A transfer occurs when tvalid && tready, so at most one word is accepted per frame.
  - When enable_i=0, tready stays low and upstream backpressure holds the word; the block does not drop it.
  - Changing enable_i takes effect at the next slot FRAME_LEN-1.
- Word check (on transfer):
  - Valid word (tdata[31:30]==2'b10 and tdata[17:8]==0): latch address and metadata, set pending.
  - Any other word is consumed, err_count_o increments, and the next frame is idle.
- Frame contents:
  - Trigger frame (pending set at slot 0; transfer in slot FRAME_LEN-1 → TRIG_CHAR on dout_o the next cycle):
    - slot0 = TRIG_CHAR
    - slot1 = addr[11:4]
    - slot2 = {addr[3:0], meta[7:4]}
    - slot3 = {meta[3:0], seq[3:0]}
    - slots 4..FRAME_LEN-2 = 8'h00
    - slot FRAME_LEN-1 = ~(XOR of slots 1..FRAME_LEN-2)
  - Idle frame: slot0 = IDLE_CHAR; slots 1..FRAME_LEN-2 = 0; last slot = 8'hFF, the same checksum rule applied to all-zero slots.
- Sequence number:
  - seq increments modulo 16 at the start of each trigger frame, with wrap 15→0.
  - The first trigger after reset carries seq=1.
  - seq_o updates in slot 0 of the trigger frame.
- Counters:
  - trig_count_o increments in slot 0 of each trigger frame.
  - err_count_o increments the cycle after a malformed transfer.
  - Both saturate at 16'hFFFF.
- Pending: cleared at slot 0 when the trigger frame begins. Latched fields hold until the next valid transfer, so frame bytes are stable for the whole frame.
- Simultaneous events:
  - A transfer in the last slot of a trigger frame queues the next trigger for back-to-back frames with no idle gap.
  - A malformed word following a valid frame yields an idle frame with no seq change.

Decomposition:
- Shared package trig_ser_pkg holds:
  - default IDLE_CHAR and TRIG_CHAR
  - the header field constant 2'b10
  - slot index constants: SLOT_HDR, SLOT_ADDR_HI, SLOT_ADDR_LO_META, SLOT_META_SEQ
  - the saturating 16-bit counter width
- One sub-module, trig_sat_counter (16-bit saturating, enable input), instantiated twice.
- Frame mux and checksum stay inline.

Test Plan:
- Reset released with no tvalid: the first dout_o bytes are 3C,00,00,00,00,00,00,FF, repeating; frame_start_o high every 8th cycle; tready high only in slot 7.
- Word 0x8AB400C5 (addr 0x2AD, meta 0xC5) presented at slot 7: the next frame is BC,2A,DC,51,00,00,00,~(2A^DC^51)=0x58; seq_o=1; trig_count_o=1.
- Three valid words back-to-back: three consecutive trigger frames with seq 1,2,3 and no idle gap. Sixteen further triggers: seq wraps through 0.
- Word 0x4AB400C5 (bad header): consumed, err_count_o=1, next frame idle, seq_o unchanged. With err_count_o preloaded at FFFF by 65535 bad words: stays FFFF.
- enable_i=0 with tvalid held: tready never asserts, only idle frames go out. Raise enable_i: the word is accepted at the next slot 7 and its trigger frame follows.
- rstn_i pulled low at slot 2 of a trigger frame: dout_o=0 next cycle, all counters and seq 0. After release: an idle frame starting at slot 0, and the aborted trigger is not resent.
